// File: rtl/rapid_pkg.sv
// Shared types for the rapid core: cache operation codes, word width,
// reset vector and the instruction-cache controller state encoding.
package rapid_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    CACHE_READ  = 1'b0,
    CACHE_WRITE = 1'b1
  } cache_operation;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    RESPOND
  } ICACHE_STATE_T;

endpackage

// File: rtl/inst_cache_ctrl_if.sv
// Fetch-side and refill-side bus of the instruction cache controller.
// master: the fetch unit / backing memory side; slave: the cache controller.
interface inst_cache_ctrl_if import rapid_pkg::*; #(
  parameter int XLEN = WORD_WIDTH
);
  logic            i_req;
  logic [XLEN-1:0] i_address;
  cache_operation  i_read_or_write;
  logic            i_invalidate;
  logic [XLEN-1:0] o_data;
  logic            o_done;
  logic            o_err;
  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic            i_mem_ready;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  logic [31:0]     o_hit_count;
  logic [31:0]     o_miss_count;

  modport master (
    output i_req, i_address, i_read_or_write, i_invalidate,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_data, o_done, o_err, o_mem_req, o_mem_addr,
    input  o_hit_count, o_miss_count
  );

  modport slave (
    input  i_req, i_address, i_read_or_write, i_invalidate,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_data, o_done, o_err, o_mem_req, o_mem_addr,
    output o_hit_count, o_miss_count
  );
endinterface

// File: rtl/icache_array.sv
// Tag, valid and data storage for a direct-mapped instruction cache.
// Writes are synchronous, reads are combinational. Only the valid bits
// are reset; tag and data contents are meaningless while a line is invalid.
module icache_array #(
  parameter int XLEN           = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 26,
  parameter int IDX_W          = $clog2(LINES),
  parameter int WORD_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_valid,
  input  logic              data_we,
  input  logic              tag_we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic [XLEN-1:0]   rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid
);
  logic [XLEN-1:0]  data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  // Valid bits: cleared by reset or bulk invalidate, set when a line's tag lands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_valid) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Data and tag storage writes.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{wr_index, wr_word}] <= wr_data;
    if (tag_we)  tag_mem[wr_index] <= wr_tag;
  end

  assign rd_data  = data_mem[{rd_index, rd_word}];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];
endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with line refill.
// Optional build macro: ICACHE_STATS_EN adds saturating hit/miss counters;
// without it both counter outputs are constant zero.
module inst_cache_ctrl import rapid_pkg::*; #(
  parameter int XLEN           = WORD_WIDTH,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  inst_cache_ctrl_if.slave   bus
);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = XLEN - OFF_W - IDX_W;

  ICACHE_STATE_T     state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  cache_operation    op_q;
  logic [WORD_W-1:0] beat_q;
  logic              pend_inv_q;
  logic              done_q, err_q;
  logic [XLEN-1:0]   data_q;

  logic              accept, clear_valid, data_we, tag_we, mem_req, hit;
  logic [XLEN-1:0]   rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              unused_byte_offset;

  wire [WORD_W-1:0] req_word  = addr_q[OFF_W-1:2];
  wire [IDX_W-1:0]  req_index = addr_q[OFF_W+IDX_W-1:OFF_W];
  wire [TAG_W-1:0]  req_tag   = addr_q[XLEN-1:OFF_W+IDX_W];

  // Instruction words are always word aligned; the byte offset is dropped.
  assign unused_byte_offset = ^addr_q[1:0];

  icache_array #(
    .XLEN(XLEN), .LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TAG_W)
  ) u_array (
    .clk(i_clk), .reset_n(i_reset_n), .clear_valid(clear_valid),
    .data_we(data_we), .tag_we(tag_we),
    .wr_index(req_index), .wr_word(beat_q), .wr_data(bus.i_mem_rdata), .wr_tag(req_tag),
    .rd_index(req_index), .rd_word(req_word),
    .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  // Next-state and array-control decode.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    clear_valid = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    mem_req     = 1'b0;
    case (state_q)
      IDLE: begin
        // A deferred invalidate is applied here without blocking a request;
        // a live invalidate pulse wins over a request for this cycle.
        clear_valid = bus.i_invalidate || pend_inv_q;
        if (bus.i_req && !bus.i_invalidate) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (op_q == CACHE_WRITE || hit) state_d = RESPOND;
        else                            state_d = REFILL_REQ;
      end
      REFILL_REQ: begin
        mem_req = 1'b1;
        if (bus.i_mem_ready) state_d = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (bus.i_mem_rvalid && i_reset_n) begin
          data_we = 1'b1;
          if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) begin
            tag_we  = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, beat counter, deferred invalidate and response flops.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pend_inv_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (data_we) beat_q <= beat_q + 1'b1;
      if (state_q == IDLE)       pend_inv_q <= 1'b0;
      else if (bus.i_invalidate) pend_inv_q <= 1'b1;
      done_q <= (state_q == RESPOND);
      err_q  <= (state_q == RESPOND) && (op_q == CACHE_WRITE);
      data_q <= (state_q == RESPOND && op_q == CACHE_READ) ? rd_data : '0;
    end
  end

  // Request capture; held for the whole transaction.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q <= bus.i_address;
      op_q   <= bus.i_read_or_write;
    end
  end

  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_data     = data_q;
  assign bus.o_mem_req  = mem_req;
  assign bus.o_mem_addr = mem_req ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Read hit/miss statistics, counted once per lookup.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP && op_q == CACHE_READ) begin
      if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else     miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign bus.o_hit_count  = hit_cnt_q;
  assign bus.o_miss_count = miss_cnt_q;
`else
  assign bus.o_hit_count  = '0;
  assign bus.o_miss_count = '0;
`endif
endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Self-checking bench for inst_cache_ctrl: directed scenarios plus random
// traffic, checked against a line-level model of a direct-mapped cache.
module tb_inst_cache_ctrl;
  import rapid_pkg::*;

  localparam int XLEN  = 32;
  localparam int LINES = 16;
  localparam int WPL   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_cache_ctrl_if #(.XLEN(XLEN)) bus();

  inst_cache_ctrl #(.XLEN(XLEN), .LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // Model state: which lines hold which tag, and statistics.
  bit           m_valid [LINES];
  logic [31:0]  m_tag   [LINES];
  int unsigned  m_hits = 0, m_misses = 0;

  // Expectations for the transaction in flight.
  bit           out_busy = 0;
  bit           exp_miss = 0;
  bit           exp_err  = 0;
  int           exp_done_cyc = -1;
  logic [31:0]  exp_data = 0, exp_line = 0;

  // Observations of the last finished transaction.
  logic [31:0]  last_data;
  bit           last_err, saw_mem_req;
  int           last_lat, done_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Backing memory contents: line 0 holds 0x11..0x44, elsewhere a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return (32'(a[3:2]) + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef ICACHE_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done", 32'(bus.o_done), 32'(out_busy && cyc == exp_done_cyc));
      if (bus.o_done && out_busy) begin
        check("data",  bus.o_data, exp_data);
        check("err",   32'(bus.o_err), 32'(exp_err));
        check("hits",  bus.o_hit_count,  exp_cnt(m_hits));
        check("miss",  bus.o_miss_count, exp_cnt(m_misses));
      end
      if (bus.o_mem_req) begin
        check("mem_req_allowed", 32'(out_busy && exp_miss), 32'd1);
        check("mem_addr", bus.o_mem_addr, exp_line);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_invalidate = 1'b0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0;
    out_busy = 0; model_clear(); m_hits = 0; m_misses = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One fetch transaction, also acting as backing memory. inv_beat >= 0 pulses
  // invalidate after that many refill beats; rst_beat >= 0 resets there instead.
  task automatic do_req(input logic [31:0] addr, input cache_operation op,
                        input int inv_beat, input bit inv_with_req, input int rst_beat);
    int idx, req_edge, beats;
    logic [31:0] tag;
    bit hit, acc, rq_prev, rd_prev, rv_prev, fin, inv_done, pend;
    idx = int'((addr >> 4) % LINES);
    tag = addr >> 8;
    bus.i_req = 1'b1; bus.i_address = addr; bus.i_read_or_write = op;
    bus.i_invalidate = inv_with_req;
    if (inv_with_req) model_clear();
    hit = m_valid[idx] && (m_tag[idx] == tag);
    req_edge = cyc + 1 + (inv_with_req ? 1 : 0);
    exp_err  = (op == CACHE_WRITE);
    exp_data = exp_err ? 32'h0 : mem_word({addr[31:2], 2'b00});
    exp_miss = !exp_err && !hit;
    exp_line = {addr[31:4], 4'h0};
    exp_done_cyc = exp_miss ? -1 : req_edge + 2;
    if (!exp_err) begin
      if (hit) m_hits++;
      else     m_misses++;
    end
    out_busy = 1;
    acc = 0; beats = 0; rq_prev = 0; rd_prev = 0; rv_prev = 0;
    fin = 0; inv_done = 0; pend = 0; saw_mem_req = 0;
    for (int g = 0; g < 300 && !fin; g++) begin
      @(posedge clk); #1;
      bus.i_invalidate = 1'b0;
      if (rq_prev && rd_prev) acc = 1;
      if (rv_prev) beats++;
      if (bus.o_mem_req) saw_mem_req = 1;
      if (bus.o_done) begin
        fin = 1;
      end else if (rst_beat >= 0 && acc && beats == rst_beat) begin
        rst_n = 1'b0;
        bus.i_req = 1'b0; out_busy = 0;
        model_clear(); m_hits = 0; m_misses = 0;
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_done",    32'(bus.o_done), 32'd0);
        check("rst_data",    bus.o_data, 32'd0);
        check("rst_hits",    bus.o_hit_count, 32'd0);
        check("rst_miss",    bus.o_miss_count, 32'd0);
        for (int s = 0; s < 6; s++) begin
          bus.i_mem_rvalid = 1'($urandom_range(1));
          bus.i_mem_rdata  = $urandom;
          @(posedge clk); #1;
          check("rst_stray_mem_req", 32'(bus.o_mem_req), 32'd0);
        end
        bus.i_mem_rvalid = 1'b0;
        return;
      end else begin
        rq_prev = bus.o_mem_req;
        bus.i_mem_ready = bus.o_mem_req ? ($urandom_range(2) != 0) : 1'($urandom_range(1));
        rd_prev = bus.i_mem_ready;
        if (acc && beats < WPL) begin
          bus.i_mem_rvalid = ($urandom_range(3) != 0);
          bus.i_mem_rdata  = mem_word(exp_line + 32'(4 * beats));
          rv_prev = bus.i_mem_rvalid;
          if (rv_prev && beats == WPL - 1) exp_done_cyc = cyc + 2;
        end else begin
          bus.i_mem_rvalid = ($urandom_range(3) == 0);
          bus.i_mem_rdata  = $urandom;
          rv_prev = 0;
        end
        if (inv_beat >= 0 && acc && beats == inv_beat && !inv_done) begin
          bus.i_invalidate = 1'b1;
          inv_done = 1; pend = 1;
        end
      end
    end
    bus.i_req = 1'b0; bus.i_invalidate = 1'b0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0;
    if (!fin) begin
      check("timeout_done", 32'd0, 32'd1);
      do_reset();
      return;
    end
    last_data = bus.o_data; last_err = bus.o_err;
    last_lat = cyc - req_edge; done_at = cyc;
    @(negedge clk); #1;
    out_busy = 0;
    if (exp_miss) begin m_valid[idx] = 1'b1; m_tag[idx] = tag; end
    if (pend) model_clear();
  endtask

  task automatic do_inv();
    bus.i_invalidate = 1'b1;
    model_clear();
    @(posedge clk); #1;
    bus.i_invalidate = 1'b0;
  endtask

  initial begin
    int prev_done;
    bus.i_req = 1'b0; bus.i_address = '0; bus.i_read_or_write = CACHE_READ;
    bus.i_invalidate = 1'b0; bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_done",     32'(bus.o_done), 32'd0);
    check("reset_err",      32'(bus.o_err), 32'd0);
    check("reset_data",     bus.o_data, 32'd0);
    check("reset_mem_req",  32'(bus.o_mem_req), 32'd0);
    check("reset_mem_addr", bus.o_mem_addr, 32'd0);
    check("reset_hits",     bus.o_hit_count, 32'd0);
    check("reset_miss",     bus.o_miss_count, 32'd0);
    @(negedge clk); #1;

    // Cold miss on line 0, then a hit in the same line.
    do_req(32'h0, CACHE_READ, -1, 0, -1);
    check("cold_miss_refill", 32'(saw_mem_req), 32'd1);
    check("cold_miss_data",   last_data, 32'h11);
    check("cold_miss_err",    32'(last_err), 32'd0);
    do_req(32'h8, CACHE_READ, -1, 0, -1);
    check("hit_data",    last_data, 32'h33);
    check("hit_latency", 32'(last_lat), 32'd2);
    check("hit_no_refill", 32'(saw_mem_req), 32'd0);

    // Conflict eviction and re-fetch.
    do_req(32'h100, CACHE_READ, -1, 0, -1);
    check("evict_data", last_data, 32'h6D23_B100);
    check("evict_refill", 32'(saw_mem_req), 32'd1);
    do_req(32'h0, CACHE_READ, -1, 0, -1);
    check("reread_refill", 32'(saw_mem_req), 32'd1);
    check("reread_data", last_data, 32'h11);

    // Write is rejected and leaves the line intact.
    do_req(32'h4, CACHE_WRITE, -1, 0, -1);
    check("write_err",  32'(last_err), 32'd1);
    check("write_data", last_data, 32'd0);
    do_req(32'h4, CACHE_READ, -1, 0, -1);
    check("after_write_hit", 32'(saw_mem_req), 32'd0);
    check("after_write_data", last_data, 32'h22);

    // Invalidate during refill: response still correct, line gone after.
    do_req(32'h20, CACHE_READ, 2, 0, -1);
    check("inv_refill_data", last_data, 32'h9CB5_3620);
    do_req(32'h20, CACHE_READ, -1, 0, -1);
    check("inv_refill_then_miss", 32'(saw_mem_req), 32'd1);

    // Invalidate together with a request in IDLE: invalidate wins, request follows.
    do_req(32'h20, CACHE_READ, -1, 1, -1);
    check("inv_with_req_miss", 32'(saw_mem_req), 32'd1);

    // Back-to-back hits complete every 3 cycles.
    do_req(32'h24, CACHE_READ, -1, 0, -1);
    prev_done = done_at;
    do_req(32'h28, CACHE_READ, -1, 0, -1);
    check("b2b_gap", 32'(done_at - prev_done), 32'd3);

    // Reset in the middle of a refill.
    do_req(32'h40, CACHE_READ, -1, 0, 2);
    do_req(32'h40, CACHE_READ, -1, 0, -1);
    check("after_reset_refill", 32'(saw_mem_req), 32'd1);

    // Invalidate pulse while idle.
    do_inv();
    do_req(32'h40, CACHE_READ, -1, 0, -1);
    check("idle_inv_miss", 32'(saw_mem_req), 32'd1);

    // Random traffic over a few conflicting tags.
    for (int t = 0; t < 120; t++) begin
      logic [31:0] a;
      cache_operation op;
      int ib, rb;
      a  = (32'($urandom_range(2)) << 8) | (32'($urandom_range(3)) << 4) |
           (32'($urandom_range(3)) << 2);
      op = ($urandom_range(7) == 0) ? CACHE_WRITE : CACHE_READ;
      ib = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
      rb = ($urandom_range(29) == 0) ? int'($urandom_range(3)) : -1;
      if ($urandom_range(15) == 0) do_inv();
      do_req(a, op, ib, ($urandom_range(9) == 0), rb);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/inst_cache_ctrl.md
INST_CACHE_CTRL -- requirements
Module: inst_cache_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-003 Parameter WORDS_PER_LINE, default 4, XLEN-bit words per line (power of two).
REQ-004 Port i_clk  input  1  sole clock; all logic on posedge.
REQ-005 Port i_reset_n  input  1  synchronous, active-low reset.
REQ-006 Port i_req  input  1  fetch request; i_address and i_read_or_write held stable while high until o_done.
REQ-007 Port i_address  input  XLEN  byte address of the requested instruction word.
REQ-008 Port i_read_or_write  input  cache_operation  requested operation.
REQ-009 Port i_invalidate  input  1  one-cycle pulse that clears all valid bits.
REQ-010 Port o_data  output  XLEN  requested word, valid only while o_done is high.
REQ-011 Port o_done  output  1  one-cycle completion pulse.
REQ-012 Port o_err  output  1  high with o_done when the request was rejected.
REQ-013 Port o_mem_req / o_mem_addr  output  1 / XLEN  line-refill request and line-aligned byte address.
REQ-014 Port i_mem_ready  input  1  backing memory accepts o_mem_req this cycle.
REQ-015 Port i_mem_rvalid / i_mem_rdata  input  1 / XLEN  refill beat, ascending word order.
REQ-016 Port o_hit_count / o_miss_count  output  32  statistics counters.

Function
REQ-017 The block SHALL decode the address as follows: bits [1:0] ignored; next log2(WORDS_PER_LINE) bits select the word; next log2(LINES) bits select the index; remaining bits form the tag.
REQ-018 The FSM SHALL have the states IDLE, LOOKUP, REFILL_REQ, REFILL_DATA and RESPOND.
REQ-019 In IDLE, with i_req high, the FSM SHALL register the address and operation and go to LOOKUP.
REQ-020 In LOOKUP, a CACHE_WRITE SHALL go to RESPOND with o_err=1 and o_data=0, and no array change SHALL occur.
REQ-021 In LOOKUP, a valid line with matching tag (hit) SHALL go to RESPOND; otherwise (miss) the FSM SHALL go to REFILL_REQ.
REQ-022 Hit latency: if i_req is sampled at edge k, o_done SHALL be high during the cycle after edge k+2, for exactly one cycle.
REQ-023 REFILL_REQ SHALL hold o_mem_req=1 with the line-aligned o_mem_addr until a cycle in which i_mem_ready=1, then go to REFILL_DATA with o_mem_req=0.
REQ-024 REFILL_DATA SHALL write each i_mem_rvalid beat into the data array at a beat counter running from 0 to WORDS_PER_LINE-1.
REQ-025 On the last beat, REFILL_DATA SHALL write the tag, set the valid bit and go to RESPOND; cycles without i_mem_rvalid SHALL stall the counter.
REQ-026 RESPOND SHALL assert o_done with the requested word (from the array, including freshly refilled data) and return to IDLE.
REQ-027 The FSM SHALL not accept a new request in the RESPOND cycle; back-to-back hits SHALL complete every 3 cycles.
REQ-028 i_invalidate in IDLE SHALL clear all valid bits that cycle and SHALL take priority over i_req, which is then accepted in the next cycle.
REQ-029 i_invalidate in any other state SHALL set a pending flag, applied on the next IDLE cycle; the line being refilled SHALL still respond with the correct data first.
REQ-030 i_mem_rvalid outside REFILL_DATA SHALL be ignored.
REQ-031 A request dropped before o_done is illegal; the in-flight transaction SHALL still complete.

Reset
REQ-032 When i_reset_n=0 at a clock edge: state=IDLE, all valid bits=0, o_done=0, o_err=0, o_data=0, o_mem_req=0, o_mem_addr=0, beat counter=0, pending-invalidate=0, counters=0.
REQ-033 Reset mid-refill SHALL abandon the refill, leave the line invalid, and ignore remaining memory beats.

Configuration
REQ-034 With ICACHE_STATS_EN defined, o_hit_count/o_miss_count SHALL increment once per read hit/miss in LOOKUP and saturate at 0xFFFFFFFF.
REQ-035 Without ICACHE_STATS_EN, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-036 cache_operation (CACHE_READ, CACHE_WRITE), WORD_WIDTH and RESET_VECTOR SHALL come from rapid_pkg; a new ICACHE_STATE_T enum SHALL be added there.
REQ-037 Tag, valid and data storage SHALL live in one sub-module, icache_array (synchronous write, combinational read).

Verification
REQ-038 Reset, then read 0x0000_0000 -> miss; o_mem_addr=0x0; four beats 0x11,0x22,0x33,0x44 -> o_done, o_data=0x11, o_err=0.
REQ-039 Then read 0x0000_0008 -> hit, o_done 3 cycles after request, o_data=0x33, no o_mem_req.
REQ-040 Read 0x0000_0100 (same index, new tag) -> miss, refill evicts line; re-read 0x0 -> miss again.
REQ-041 CACHE_WRITE to 0x4 -> o_done=1, o_err=1, o_data=0; subsequent read 0x4 -> hit, returns 0x22.
REQ-042 i_invalidate during REFILL_DATA beat 2 -> request completes correctly; next read of the same address misses.
REQ-043 i_reset_n=0 after beat 1 -> o_mem_req=0, state IDLE, stray beats ignored; with ICACHE_STATS_EN, counters = 0.
